// File: rtl/dap_delay_calibrator.sv
// IODELAY tap sweep calibrator: writes each tap to the GPIO block, requests a DAP test
// transfer, and programs the midpoint of the longest passing run. Optional: DAP_DLY_CAL_TIMEOUT_EN.
module dap_delay_calibrator #(
    parameter int ADDRWIDTH     = 12,
    parameter int GPIO_BASE     = 0,
    parameter int MAX_TAP       = 255,
    parameter int SETTLE_CYCLES = 16,
    parameter int TEST_TIMEOUT  = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cal_start,
    input  logic                 cal_abort,
    input  logic [2:0]           cal_lane,
    input  logic [7:0]           cal_init_tap,
    output logic                 cal_busy,
    output logic                 cal_done,
    output logic                 cal_ok,
    output logic [7:0]           win_lo,
    output logic [7:0]           win_hi,
    output logic [7:0]           result_tap,
    output logic                 test_req,
    input  logic                 test_ack,
    input  logic                 test_pass,
    output logic                 mem_write_en,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_byte_strobe
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_SETTLE, S_TEST, S_EVAL, S_FINAL, S_DONE
    } state_t;

    localparam logic [ADDRWIDTH-1:0] ADDR_LO  = ADDRWIDTH'(GPIO_BASE);
    localparam logic [ADDRWIDTH-1:0] ADDR_HI  = ADDRWIDTH'(GPIO_BASE + 4);
    localparam logic [8:0]           MAX_TAP9 = 9'(MAX_TAP);

    state_t                 r_state;
    logic [2:0]             r_lane;
    logic [7:0]             r_init;
    logic [8:0]             r_tap;
    logic [7:0]             r_settle;
    logic                   r_pass;
    logic                   r_abort;
    logic [7:0]             r_cur_start;
    logic [8:0]             r_cur_len;
    logic [7:0]             r_best_lo;
    logic [7:0]             r_best_hi;
    logic [8:0]             r_best_len;
    logic [7:0]             r_res;
    logic                   r_res_ok;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_ok;
    logic [7:0]             r_win_lo;
    logic [7:0]             r_win_hi;
    logic [7:0]             r_result;
    logic                   r_req;
    logic                   r_we;
    logic [ADDRWIDTH-1:0]   r_addr;
    logic [31:0]            r_wdata;
    logic [3:0]             r_strb;
`ifdef DAP_DLY_CAL_TIMEOUT_EN
    localparam int TO_W = $clog2(TEST_TIMEOUT + 1);
    logic [TO_W-1:0]        r_to;
`endif

    function automatic logic [1:0] lane_byte(input logic [2:0] l);
        case (l)
            3'd0:    return 2'd1;
            3'd1:    return 2'd2;
            3'd2:    return 2'd3;
            3'd3:    return 2'd0;
            3'd4:    return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

    logic [2:0]           w_wr_lane;
    logic [7:0]           w_wr_tap;
    logic [1:0]           w_wr_byte;
    logic [ADDRWIDTH-1:0] w_wr_addr;
    logic [31:0]          w_wr_data;
    logic [3:0]           w_wr_strb;
    logic [8:0]           w_sum;
    logic                 w_final_ok;
    logic [7:0]           w_final_tap;
    logic [8:0]           w_new_len;
    logic [7:0]           w_new_start;
    logic                 w_abort_now;
    logic [8:0]           w_tap_nxt;

    assign w_tap_nxt   = r_tap + 9'd1;
    assign w_sum       = {1'b0, r_best_lo} + {1'b0, r_best_hi};
    // An abort arriving in the FINAL cycle itself still forces the restore value.
    assign w_final_ok  = !(r_abort || cal_abort) && (r_best_len != 9'd0);
    assign w_final_tap = w_final_ok ? w_sum[8:1] : r_init;
    assign w_new_len   = r_cur_len + 9'd1;
    assign w_new_start = (r_cur_len == 9'd0) ? r_tap[7:0] : r_cur_start;
    assign w_abort_now = cal_abort && (r_state == S_WRITE || r_state == S_SETTLE ||
                                       r_state == S_TEST  || r_state == S_EVAL);

    // Shared write formatter: IDLE issues tap 0, EVAL the next tap, FINAL the result.
    always_comb begin
        w_wr_lane = (r_state == S_IDLE) ? cal_lane : r_lane;
        case (r_state)
            S_EVAL:  w_wr_tap = w_tap_nxt[7:0];
            S_FINAL: w_wr_tap = w_final_tap;
            default: w_wr_tap = 8'd0;
        endcase
        w_wr_byte = lane_byte(w_wr_lane);
        w_wr_addr = (w_wr_lane < 3'd3) ? ADDR_LO : ADDR_HI;
        w_wr_data = {24'd0, w_wr_tap} << {w_wr_byte, 3'b000};
        w_wr_strb = 4'b0001 << w_wr_byte;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_lane      <= '0;
            r_init      <= '0;
            r_tap       <= '0;
            r_settle    <= '0;
            r_pass      <= 1'b0;
            r_abort     <= 1'b0;
            r_cur_start <= '0;
            r_cur_len   <= '0;
            r_best_lo   <= '0;
            r_best_hi   <= '0;
            r_best_len  <= '0;
            r_res       <= '0;
            r_res_ok    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ok        <= 1'b0;
            r_win_lo    <= '0;
            r_win_hi    <= '0;
            r_result    <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_strb      <= '0;
`ifdef DAP_DLY_CAL_TIMEOUT_EN
            r_to        <= '0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
            if (w_abort_now) begin
                r_abort <= 1'b1;
                r_req   <= 1'b0;
                r_state <= S_FINAL;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cal_start) begin
                            if (cal_lane <= 3'd5) begin
                                r_lane      <= cal_lane;
                                r_init      <= cal_init_tap;
                                r_tap       <= '0;
                                r_cur_start <= '0;
                                r_cur_len   <= '0;
                                r_best_lo   <= '0;
                                r_best_hi   <= '0;
                                r_best_len  <= '0;
                                r_abort     <= 1'b0;
                                r_busy      <= 1'b1;
                                r_ok        <= 1'b0;
                                r_we        <= 1'b1;
                                r_addr      <= w_wr_addr;
                                r_wdata     <= w_wr_data;
                                r_strb      <= w_wr_strb;
                                r_state     <= S_WRITE;
                            end else begin
                                r_done   <= 1'b1;
                                r_ok     <= 1'b0;
                                r_win_lo <= '0;
                                r_win_hi <= '0;
                            end
                        end
                    end
                    S_WRITE: begin
                        r_settle <= 8'(SETTLE_CYCLES);
                        r_state  <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (r_settle <= 8'd1) begin
                            r_req   <= 1'b1;
                            r_state <= S_TEST;
`ifdef DAP_DLY_CAL_TIMEOUT_EN
                            r_to    <= '0;
`endif
                        end else begin
                            r_settle <= r_settle - 8'd1;
                        end
                    end
                    S_TEST: begin
                        if (test_ack) begin
                            r_pass  <= test_pass;
                            r_req   <= 1'b0;
                            r_state <= S_EVAL;
`ifdef DAP_DLY_CAL_TIMEOUT_EN
                        end else if (r_to == TO_W'(TEST_TIMEOUT - 1)) begin
                            r_pass  <= 1'b0;
                            r_req   <= 1'b0;
                            r_state <= S_EVAL;
                        end else begin
                            r_to <= r_to + 1'b1;
`endif
                        end
                    end
                    S_EVAL: begin
                        if (r_pass) begin
                            r_cur_len   <= w_new_len;
                            r_cur_start <= w_new_start;
                            if (w_new_len > r_best_len) begin
                                r_best_lo  <= w_new_start;
                                r_best_hi  <= r_tap[7:0];
                                r_best_len <= w_new_len;
                            end
                        end else begin
                            r_cur_len <= '0;
                        end
                        if (r_tap == MAX_TAP9) begin
                            r_state <= S_FINAL;
                        end else begin
                            r_tap   <= w_tap_nxt;
                            r_we    <= 1'b1;
                            r_addr  <= w_wr_addr;
                            r_wdata <= w_wr_data;
                            r_strb  <= w_wr_strb;
                            r_state <= S_WRITE;
                        end
                    end
                    S_FINAL: begin
                        r_res    <= w_final_tap;
                        r_res_ok <= w_final_ok;
                        r_we     <= 1'b1;
                        r_addr   <= w_wr_addr;
                        r_wdata  <= w_wr_data;
                        r_strb   <= w_wr_strb;
                        r_state  <= S_DONE;
                    end
                    S_DONE: begin
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_ok     <= r_res_ok;
                        r_win_lo <= r_res_ok ? r_best_lo : 8'd0;
                        r_win_hi <= r_res_ok ? r_best_hi : 8'd0;
                        r_result <= r_res;
                        r_state  <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign cal_busy        = r_busy;
    assign cal_done        = r_done;
    assign cal_ok          = r_ok;
    assign win_lo          = r_win_lo;
    assign win_hi          = r_win_hi;
    assign result_tap      = r_result;
    assign test_req        = r_req;
    assign mem_write_en    = r_we;
    assign mem_addr        = r_addr;
    assign mem_wdata       = r_wdata;
    assign mem_byte_strobe = r_strb;

endmodule

// File: tb/tb_dap_delay_calibrator.sv
// Scoreboard bench for dap_delay_calibrator: expected GPIO writes and completions are queued
// at stimulus time and checked by a monitor on the falling clock edge.
module tb_dap_delay_calibrator;
    localparam int         AW   = 12;
    localparam logic [11:0] BASE = 12'h100;

    logic          clk = 1'b0, resetn = 1'b0;
    logic          cal_start = 1'b0, cal_abort = 1'b0;
    logic [2:0]    cal_lane = '0;
    logic [7:0]    cal_init_tap = '0;
    logic          test_ack = 1'b0, test_pass = 1'b0;
    logic          cal_busy, cal_done, cal_ok, test_req, mem_write_en;
    logic [7:0]    win_lo, win_hi, result_tap;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_byte_strobe;

    always #5 clk = ~clk;

    dap_delay_calibrator #(.ADDRWIDTH(AW), .GPIO_BASE(int'(BASE)), .MAX_TAP(255),
                           .SETTLE_CYCLES(3), .TEST_TIMEOUT(64)) dut (
        .clk(clk), .resetn(resetn), .cal_start(cal_start), .cal_abort(cal_abort),
        .cal_lane(cal_lane), .cal_init_tap(cal_init_tap), .cal_busy(cal_busy),
        .cal_done(cal_done), .cal_ok(cal_ok), .win_lo(win_lo), .win_hi(win_hi),
        .result_tap(result_tap), .test_req(test_req), .test_ack(test_ack),
        .test_pass(test_pass), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_byte_strobe(mem_byte_strobe)
    );

    typedef struct packed { logic [11:0] a; logic [31:0] d; logic [3:0] s; } wr_t;
    typedef struct packed { logic ok; logic [7:0] lo; logic [7:0] hi; logic [7:0] res; } dn_t;

    wr_t          wq[$];
    dn_t          dq[$];
    int           tests = 0, fails = 0, done_seen = 0;
    bit           mon_en = 1'b1;
    logic [255:0] pass_vec = '0;
    int           resp_tap = 0, stop_tap = -1, lat_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Lane map written out from the register layout: lanes 0-2 at BASE bytes 1..3, 3-5 at BASE+4 bytes 0..2.
    function automatic wr_t mkwr(input int lane, input logic [7:0] tap);
        int  b;
        wr_t w;
        case (lane)
            0: b = 1; 1: b = 2; 2: b = 3;
            3: b = 0; 4: b = 1; default: b = 2;
        endcase
        w.a = (lane < 3) ? BASE : BASE + 12'd4;
        w.d = {24'd0, tap} << (8 * b);
        w.s = 4'b0001 << b;
        return w;
    endfunction

    // Test-engine model: acks each request after two cycles with the pass map entry for its tap.
    initial forever begin
        @(posedge clk); #1;
        if (test_ack) begin
            test_ack = 1'b0;
            test_pass = 1'b0;
        end else if (test_req && resp_tap != stop_tap) begin
            if (lat_cnt == 1) begin
                test_ack = 1'b1;
                test_pass = pass_vec[resp_tap];
                resp_tap++;
                lat_cnt = 0;
            end else lat_cnt++;
        end
    end

    always @(negedge clk) begin
        if (resetn && mon_en) begin
            if (mem_write_en) begin
                wr_t e;
                chk("we_req_exclusive", {63'd0, test_req}, 64'd0);
                if (wq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", mem_addr, mem_wdata);
                end else begin
                    e = wq.pop_front();
                    chk("wr_addr", 64'(mem_addr), 64'(e.a));
                    chk("wr_data", 64'(mem_wdata), 64'(e.d));
                    chk("wr_strobe", 64'(mem_byte_strobe), 64'(e.s));
                end
            end else begin
                chk("idle_bus_zero", 64'({mem_addr, mem_wdata, mem_byte_strobe}), 64'd0);
            end
            if (cal_done) begin
                dn_t e;
                done_seen++;
                chk("done_busy_low", {63'd0, cal_busy}, 64'd0);
                if (dq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got ok %0d result 0x%0h, expected none", cal_ok, result_tap);
                end else begin
                    e = dq.pop_front();
                    chk("done_ok", {63'd0, cal_ok}, {63'd0, e.ok});
                    chk("done_win_lo", 64'(win_lo), 64'(e.lo));
                    chk("done_win_hi", 64'(win_hi), 64'(e.hi));
                    chk("done_result", 64'(result_tap), 64'(e.res));
                end
            end
        end
    end

    task automatic pulse_start(input int lane, input logic [7:0] init);
        @(posedge clk); #1;
        cal_lane = 3'(lane);
        cal_init_tap = init;
        cal_start = 1'b1;
        @(posedge clk); #1;
        cal_start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input string nm);
        int i;
        for (i = 0; i < 20000 && done_seen == n0; i++) @(posedge clk);
        chk(nm, 64'(done_seen - n0), 64'd1);
        repeat (2) @(posedge clk);
    endtask

    task automatic sweep(input int lane, input logic [7:0] init, input logic [255:0] pv,
                         input logic ok, input logic [7:0] lo, input logic [7:0] hi,
                         input logic [7:0] res, input string nm);
        int n0;
        pass_vec = pv;
        resp_tap = 0;
        lat_cnt = 0;
        for (int t = 0; t < 256; t++) wq.push_back(mkwr(lane, 8'(t)));
        wq.push_back(mkwr(lane, res));
        dq.push_back('{ok, lo, hi, res});
        n0 = done_seen;
        pulse_start(lane, init);
        chk({nm, "_first_write"}, {63'd0, mem_write_en}, 64'd1);
        chk({nm, "_busy"}, {63'd0, cal_busy}, 64'd1);
        wait_done(n0, {nm, "_done"});
    endtask

    function automatic logic [255:0] win(input int a, input int b);
        logic [255:0] v;
        v = '0;
        for (int i = a; i <= b; i++) v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        int n0, i;
        repeat (3) @(posedge clk); #1;
        chk("rst_outputs", 64'({cal_busy, cal_done, cal_ok, win_lo, win_hi, result_tap, test_req}), 64'd0);
        chk("rst_bus", 64'({mem_write_en, mem_addr, mem_wdata, mem_byte_strobe}), 64'd0);
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        // Abort while idle must do nothing.
        n0 = done_seen;
        @(posedge clk); #1 cal_abort = 1'b1;
        @(posedge clk); #1 cal_abort = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("idle_abort_ignored", 64'({cal_busy, 32'(done_seen - n0)}), 64'd0);

        // Lane 4 window 40..60, with a stray start mid-sweep that must be ignored.
        fork
            sweep(4, 8'h33, win(40, 60), 1'b1, 8'd40, 8'd60, 8'd50, "lane4");
            begin
                repeat (200) @(posedge clk); #1;
                cal_lane = 3'd0; cal_start = 1'b1;
                @(posedge clk); #1 cal_start = 1'b0;
            end
        join

        sweep(1, 8'h33, win(10, 19) | win(100, 109), 1'b1, 8'd10, 8'd19, 8'd14, "tie_earlier");
        sweep(3, 8'h33, win(10, 19) | win(100, 111), 1'b1, 8'd100, 8'd111, 8'd105, "longer_later");
        sweep(2, 8'h33, win(250, 255), 1'b1, 8'd250, 8'd255, 8'd252, "top_edge");
        sweep(5, 8'h33, '0, 1'b0, 8'd0, 8'd0, 8'h33, "all_fail");

        // Abort in TEST at tap 7 on lane 0.
        pass_vec = '1; resp_tap = 0; lat_cnt = 0; stop_tap = 7;
        for (int t = 0; t < 8; t++) wq.push_back(mkwr(0, 8'(t)));
        wq.push_back(mkwr(0, 8'h33));
        dq.push_back('{1'b0, 8'd0, 8'd0, 8'h33});
        n0 = done_seen;
        pulse_start(0, 8'h33);
        for (i = 0; i < 5000 && !(test_req && !test_ack && resp_tap == 7); i++) begin
            @(posedge clk); #2;
        end
        chk("abort_reached_tap7", 64'(i < 5000), 64'd1);
        cal_abort = 1'b1;
        @(posedge clk); #2;
        cal_abort = 1'b0;
        chk("abort_req_drop", {63'd0, test_req}, 64'd0);
        test_ack = 1'b1; test_pass = 1'b1;
        wait_done(n0, "abort_done");
        stop_tap = -1;

        // Invalid lane: immediate done, no busy, no write.
        dq.push_back('{1'b0, 8'd0, 8'd0, 8'h33});
        n0 = done_seen;
        pulse_start(6, 8'h55);
        chk("lane6_done", {63'd0, cal_done}, 64'd1);
        chk("lane6_busy", {63'd0, cal_busy}, 64'd0);
        @(posedge clk); #1;
        chk("lane6_busy_after", 64'({cal_busy, cal_done}), 64'd0);
        repeat (3) @(posedge clk);
        chk("lane6_done_count", 64'(done_seen - n0), 64'd1);
        chk("wq_empty", 64'(wq.size()), 64'd0);
        chk("dq_empty", 64'(dq.size()), 64'd0);

        // Reset in the middle of a sweep.
        mon_en = 1'b0;
        pass_vec = '1; resp_tap = 0; lat_cnt = 0;
        pulse_start(0, 8'h44);
        repeat (40) @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("midrst_outputs", 64'({cal_busy, cal_done, cal_ok, win_lo, win_hi, result_tap, test_req}), 64'd0);
        chk("midrst_bus", 64'({mem_write_en, mem_addr, mem_wdata, mem_byte_strobe}), 64'd0);
        repeat (2) @(posedge clk); #1;
        resetn = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dap_delay_calibrator.md
# dap_delay_calibrator

Sequencer that automatically calibrates one IODELAY lane of the DAP GPIO block. It sweeps the lane's 8-bit tap value through the GPIO block's AHB MEM slave port. At each tap it asks the DAP engine for a test transfer, records the longest contiguous run of passing taps, and finally programs the midpoint of that run. It sits between the DAP controller's configuration logic and the GPIO register file, as the only writer of the delay registers while busy.

## Interface

Parameters:

- ADDRWIDTH, 12, AHB MEM address width (matches GPIO block).
- GPIO_BASE, 0, GPIO block base address.
- MAX_TAP, 255, last tap swept (0..255).
- SETTLE_CYCLES, 16, idle cycles after each tap write before testing (1..255).
- TEST_TIMEOUT, 1024, cycles to wait for test_ack (only with DAP_DLY_CAL_TIMEOUT_EN).

Ports:

- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- cal_start  in  1  one-cycle start pulse, sampled only in IDLE.
- cal_abort  in  1  abort request, any state.
- cal_lane  in  3  lane select, sampled with cal_start: 0 SWCLK_O, 1 TMS_T, 2 TMS_O, 3 TMS_I, 4 TDO_I, 5 TDI_O.
- cal_init_tap  in  8  restore value, sampled with cal_start.
- cal_busy  out  1  high from start acceptance until done.
- cal_done  out  1  one-cycle completion pulse.
- cal_ok  out  1  result valid (window found), held until next start.
- win_lo / win_hi  out  8 each  best window bounds, held.
- result_tap  out  8  tap finally written, held.
- test_req  out  1  test transfer request (level).
- test_ack  in  1  test finished; test_pass valid this cycle.
- test_pass  in  1  test result.
- mem_write_en  out  1  one-cycle write strobe to GPIO.
- mem_addr  out  ADDRWIDTH  word address.
- mem_wdata  out  32  tap placed in selected byte, other bytes 0.
- mem_byte_strobe  out  4  single-hot byte strobe.

## Operation

- Lane map: lanes 0..2 use addr GPIO_BASE+0, bytes 1/2/3. Lanes 3..5 use addr GPIO_BASE+4, bytes 0/1/2.
- States: IDLE, WRITE, SETTLE, TEST, EVAL, FINAL, DONE.
- IDLE: on cal_start with lane ≤5 → clear window trackers, tap=0, → WRITE.
- IDLE, lane 6/7: one-cycle cal_done, cal_ok=0, no write, stay IDLE.
- WRITE: one-cycle mem_write_en of the current tap → SETTLE. The settle counter loads SETTLE_CYCLES.
- SETTLE: decrement; at 0 → TEST.
- TEST: test_req=1 until the cycle test_ack=1. Latch test_pass → EVAL; test_req drops the following cycle.
- EVAL, pass: if cur_len==0, cur_start=tap; cur_len++. If cur_len (new) > best_len, then best_lo=cur_start, best_hi=tap, best_len=cur_len.
- EVAL, fail: cur_len=0.
- Ties keep the earlier window (strict >).
- EVAL exit: tap==MAX_TAP → FINAL; else tap+1 → WRITE. The tap counter is 9-bit internally; there is no wrap.
- FINAL: best_len>0 → result=(best_lo+best_hi)>>1 using a 9-bit sum, cal_ok=1. Else result=cal_init_tap, cal_ok=0. Write result (one strobe) → DONE.
- DONE: cal_done pulse, publish win_lo/win_hi/result_tap → IDLE.
- win_lo/win_hi are 0 when cal_ok=0.
- cal_abort in any busy state: test_req drops immediately → FINAL with forced cal_init_tap, cal_ok=0.
- A test_ack arriving after an abort is ignored.
- cal_start while busy is ignored. Abort in IDLE is ignored.

## Timing

- Reset: all outputs 0, state IDLE, trackers cleared.
- Start → first mem_write_en: 1 cycle.
- Per tap: 1 write + SETTLE_CYCLES + test latency + 1 EVAL.
- mem_write_en is never asserted with test_req.
- mem_addr, mem_wdata and mem_byte_strobe are valid only while mem_write_en is high; they are 0 otherwise.
- Final write → cal_done: next cycle. cal_busy falls together with cal_done.
- Reset mid-sweep: immediate return to IDLE and outputs 0. There is no restore write; the GPIO block resets its own registers.

## Configuration

- DAP_DLY_CAL_TIMEOUT_EN defined: a TEST-state counter runs. If TEST_TIMEOUT cycles pass without test_ack, test_req drops, the tap counts as fail, and the sweep continues.
- Not defined: TEST waits indefinitely for test_ack, and no counter logic is present.

## Test plan

- Lane 4, passes on taps 40..60 only, MAX_TAP=255: 256 tap writes (addr BASE+4, strobe 0010) → final write 50, cal_ok=1, win 40/60.
- Two windows, 10..19 and 100..109: equal length → earlier kept, result 14. Then 100..111 → result 105.
- All taps fail, cal_init_tap=0x33: final write 0x33, cal_ok=0, win 0/0.
- Abort during TEST at tap 7, lane 0: test_req low next cycle, single write 0x33 with strobe 0010 at BASE+0, cal_done, cal_ok=0.
- cal_lane=6: cal_done one cycle after start, no mem_write_en, cal_busy never high.
- With DAP_DLY_CAL_TIMEOUT_EN and test_ack never returned: each tap is timed out after TEST_TIMEOUT cycles, and the sweep completes with cal_ok=0.
